uart_rx_fifo: RTL
=================

// Module: uart_rx_fifo
// PURPOSE
//  Receive-side byte buffer placed directly after the UART receiver.
//  Captures each single-cycle (data, strobe) pair from the receiver into a FIFO.
//  Presents the bytes to the consumer through a first-word-fall-through valid/ready interface.
//  The receiver cannot be stalled: when the FIFO is full, incoming bytes are dropped and flagged.
// PARAMETERS
//  WIDTH  8   bits per entry; must match the receiver's WIDTH
//  DEPTH  16  number of entries; power of 2, >= 2
// PORTS
//  clk          in   1              single clock; all logic on its rising edge
//  rst          in   1              synchronous reset, active-high
//  in_data      in   WIDTH          byte from receiver; sampled only when in_valid=1
//  in_valid     in   1              one-cycle strobe per received byte; no backpressure
//  out_data     out  WIDTH          head entry; valid only while out_valid=1
//  out_valid    out  1              FIFO not empty
//  out_ready    in   1              consumer accepts head entry when out_valid & out_ready
//  level        out  $clog2(DEPTH)+1  current entry count, 0..DEPTH
//  overflow     out  1              sticky: a byte was dropped since last clear
//  overflow_clr in   1              one-cycle clear of overflow
// BEHAVIOUR
//  - Storage: DEPTH x WIDTH array. Read and write pointers are $clog2(DEPTH)+1 bits wide.
//    Empty when the pointers are equal. Full when the MSBs differ and the rest are equal.
//    Pointers wrap naturally modulo 2*DEPTH.
//  - Reset (rst=1 at an edge): pointers=0, level=0, out_valid=0, overflow=0.
//    Array contents are not reset. Reset mid-stream discards all stored bytes,
//    and an in_valid in the reset cycle is ignored.
//  - push = in_valid & (!full | pop); pop = out_valid & out_ready.
//  - Push: write in_data at wr_ptr and increment wr_ptr.
//    Latency: in_valid at edge N -> out_valid=1 and out_data=byte after edge N, if previously empty.
//  - Pop: increment rd_ptr. The next entry appears on out_data after the same edge.
//  - out_data = mem[rd_ptr[..-1:0]] (show-ahead). Must not change while out_valid & !out_ready.
//  - Full + in_valid + pop in the same cycle: push accepted, level stays DEPTH, no overflow.
//  - Full + in_valid without pop: byte dropped, array and pointers unchanged, overflow<=1 at that edge.
//  - Empty + out_ready: no pop; the pointer must not move.
//  - Empty + in_valid + out_ready: push only; the byte is visible next cycle and is not bypassed.
//  - level updates: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - overflow: set on drop, cleared by overflow_clr. If both happen in the same cycle, set wins.
//  - out_valid is registered-equivalent: derived from pointers, no combinational path from in_valid.
// CONFIGURATION
//  UART_RX_FIFO_DROP_COUNT_EN defined:
//  - Adds output drop_count [15:0]. It increments on each dropped byte and saturates at 16'hFFFF.
//  - It is cleared by rst and by overflow_clr. If a clear and a drop happen in the same cycle, the result is 1.
//  UART_RX_FIFO_DROP_COUNT_EN undefined: no drop_count port and no counter logic.
//  The overflow flag is unaffected either way.
// TESTING
//  1. Reset, then in_valid with 8'hA5, out_ready=0 -> next cycle out_valid=1, out_data=A5, level=1.
//     Assert out_ready -> out_valid=0 and level=0 after that edge.
//  2. Push 16 bytes 0x00..0x0F with out_ready=0 -> level=16, overflow=0.
//     Drain -> bytes read out 00..0F in order.
//  3. Fill to 16, then push 0x55 -> dropped, overflow=1, level=16.
//     Drain -> 0x55 is never output. overflow_clr -> overflow=0.
//  4. Full, then in_valid=0x77 with out_ready=1 in the same cycle -> level=16, overflow=0.
//     0x77 is the last byte drained.
//  5. Stream 100 bytes with a random out_ready duty cycle, never exceeding capacity ->
//     output sequence equals input sequence and pointers wrap cleanly.
//  6. Assert rst with 5 bytes held -> out_valid=0, level=0, overflow=0 next cycle.
//     With DROP_COUNT_EN: 3 drops -> drop_count=3.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side byte buffer behind the UART receiver.
// Captures (in_data, in_valid) strobes into a FIFO and presents the head
// entry through a first-word-fall-through valid/ready interface. The
// receiver cannot be stalled, so bytes arriving while full are dropped
// and recorded in a sticky overflow flag.
// Optional feature macro: UART_RX_FIFO_DROP_COUNT_EN adds a saturating
// 16-bit drop counter output (drop_count).
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
`ifdef UART_RX_FIFO_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  // Status and handshake decode; everything is derived from the registered
  // pointers, so out_valid has no combinational path from in_valid.
  // A full FIFO can still accept a byte when the head is leaving in the
  // same cycle, because the freed slot is the one being written.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    out_valid = !empty;
    pop       = out_valid && out_ready;
    push      = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    level     = wr_ptr - rd_ptr;
    out_data  = mem[rd_ptr[AW-1:0]];
  end

  // Storage write; contents are intentionally not reset, and a strobe in
  // the reset cycle is ignored.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Pointer update; both wrap naturally modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef UART_RX_FIFO_DROP_COUNT_EN
  // Saturating drop counter; a clear coinciding with a drop leaves it at 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
    end else if (drop) begin
      if (overflow_clr) begin
        drop_count <= 16'd1;
      end else if (drop_count != 16'hFFFF) begin
        drop_count <= drop_count + 16'd1;
      end
    end else if (overflow_clr) begin
      drop_count <= '0;
    end
  end
`endif

endmodule
